// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: access tags and default bus widths.
// Optional macro VRAM_CPU_READ_EN enables CPU reads (TAG_CPU_RD).
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;
  localparam int unsigned VRAM_DATA_W = 8;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VID    = 2'd1,
`ifdef VRAM_CPU_READ_EN
    TAG_CPU_RD = 2'd2,
`endif
    TAG_CPU_WR = 2'd3
  } tag_e;

  // True when the tag is any CPU access.
  function automatic logic tag_is_cpu(tag_e t);
`ifdef VRAM_CPU_READ_EN
    return (t == TAG_CPU_WR) || (t == TAG_CPU_RD);
`else
    return (t == TAG_CPU_WR);
`endif
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Video, CPU and RAM sides of the VRAM arbiter grouped as one bundle.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = vram_pkg::VRAM_ADDR_W,
  parameter int unsigned DATA_W = vram_pkg::VRAM_DATA_W
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              vid_late;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_gnt, vid_valid, vid_data, vid_late, cpu_ack, cpu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_gnt, vid_valid, vid_data, vid_late, cpu_ack, cpu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vram_arb_pick.sv
// Combinational winner selection: starved CPU first, then video, then CPU.
// With VRAM_CPU_READ_EN undefined every CPU access is a write.
module vram_arb_pick
  import vram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             vid_req,
  input  logic             cpu_eligible,
`ifdef VRAM_CPU_READ_EN
  input  logic             cpu_we,
`endif
  input  logic [CNT_W-1:0] starve_cnt,
  output tag_e             winner
);

  tag_e cpu_tag;

  // Priority decode of the current cycle's requests
  always_comb begin
    cpu_tag = TAG_CPU_WR;
`ifdef VRAM_CPU_READ_EN
    if (!cpu_we) cpu_tag = TAG_CPU_RD;
`endif
    winner = TAG_NONE;
    if (cpu_eligible && (starve_cnt == CNT_W'(MAX_WAIT))) winner = cpu_tag;
    else if (vid_req)                                      winner = TAG_VID;
    else if (cpu_eligible)                                 winner = cpu_tag;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between video scan-out and the CPU bus port.
// Video has priority; a starvation counter forces one CPU slot after
// MAX_WAIT denials. Macro VRAM_CPU_READ_EN enables CPU reads.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned DATA_W   = VRAM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk_50mhz,
  input  logic          rst,
  vram_arbiter_if.slave bus
);

  tag_e             winner;
  tag_e             tag1;
  logic             cpu_busy;
  logic [CNT_W-1:0] starve_cnt;
  logic             vid_req_g;
  logic             cpu_eligible;
  logic             cpu_win;
  logic             ack_next;

  assign vid_req_g    = bus.vid_req & ~rst;
  assign cpu_eligible = bus.cpu_req & ~cpu_busy & ~rst;
  assign cpu_win      = tag_is_cpu(winner);

  vram_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .vid_req      (vid_req_g),
    .cpu_eligible (cpu_eligible),
`ifdef VRAM_CPU_READ_EN
    .cpu_we       (bus.cpu_we),
`endif
    .starve_cnt   (starve_cnt),
    .winner       (winner)
  );

  assign bus.vid_gnt  = (winner == TAG_VID);
  assign bus.vid_late = vid_req_g & ~bus.vid_gnt;

  // Writes complete in the RAM cycle; reads complete one cycle later
  always_comb begin
    ack_next = (winner == TAG_CPU_WR);
`ifdef VRAM_CPU_READ_EN
    if (tag1 == TAG_CPU_RD) ack_next = 1'b1;
`endif
  end

  // RAM command register, loaded with the winner of this cycle
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      bus.ram_en <= (winner != TAG_NONE);
      bus.ram_we <= (winner == TAG_CPU_WR);
      if (winner == TAG_VID) bus.ram_addr <= bus.vid_addr;
      else if (cpu_win)      bus.ram_addr <= bus.cpu_addr;
      if (winner == TAG_CPU_WR) bus.ram_wdata <= bus.cpu_wdata;
    end
  end

  // Tag pipeline and result registers for video and CPU acknowledge
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      tag1          <= TAG_NONE;
      bus.vid_valid <= 1'b0;
      bus.vid_data  <= '0;
      bus.cpu_ack   <= 1'b0;
    end else begin
      tag1          <= winner;
      bus.vid_valid <= (tag1 == TAG_VID);
      if (tag1 == TAG_VID) bus.vid_data <= bus.ram_rdata;
      bus.cpu_ack   <= ack_next;
    end
  end

`ifdef VRAM_CPU_READ_EN
  // CPU read data captured alongside the read acknowledge
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)                     bus.cpu_rdata <= '0;
    else if (tag1 == TAG_CPU_RD) bus.cpu_rdata <= bus.ram_rdata;
  end
`else
  assign bus.cpu_rdata = '0;
`endif

  // One CPU op in flight: busy from win until the end of the ack cycle
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)              cpu_busy <= 1'b0;
    else if (cpu_win)     cpu_busy <= 1'b1;
    else if (bus.cpu_ack) cpu_busy <= 1'b0;
  end

  // Count consecutive denials of an eligible CPU request, saturating
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (cpu_win || !bus.cpu_req) begin
      starve_cnt <= '0;
    end else if (cpu_eligible && (starve_cnt != CNT_W'(MAX_WAIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a grant-order reference model.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_WAIT = 4;
`ifdef VRAM_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk_50mhz;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  function automatic logic [7:0] init_val(int a);
    return 8'(a * 73) ^ 8'(a >>> 3) ^ 8'h5A;
  endfunction

  // Behavioural RAM: access registered by the DUT, write lands mid access cycle
  logic [7:0] ram_mem [8192];
  assign bus.ram_rdata = ram_mem[bus.ram_addr];
  initial begin
    for (int i = 0; i < 8192; i++) ram_mem[i] = init_val(i);
    forever begin
      @(negedge clk_50mhz);
      if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) ram_mem[bus.ram_addr] = bus.ram_wdata;
    end
  end

  // Reference model: memory in grant order, results scheduled by cycle
  logic [7:0] m_mem [int];
  bit         ev_vv  [8];
  logic [7:0] ev_vd  [8];
  bit         ev_ack [8];
  bit         ev_rd  [8];
  logic [7:0] ev_rdd [8];
  int         cyc;
  bit         m_busy;
  int         m_starve;
  int         mw;
  int         mcur;
  bit         melig;

  function automatic logic [7:0] m_read(int a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  // 0 idle, 1 video, 2 cpu read, 3 cpu write
  function automatic int model_pick(bit vreq, bit creq, bit cwe, bit busy, int starve);
    bit elig;
    int ck;
    elig = creq && !busy;
    ck   = (READ_EN && !cwe) ? 2 : 3;
    if (elig && starve >= int'(MAX_WAIT)) return ck;
    if (vreq) return 1;
    if (elig) return ck;
    return 0;
  endfunction

  always @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        ev_vv[i] = 0; ev_vd[i] = '0; ev_ack[i] = 0; ev_rd[i] = 0; ev_rdd[i] = '0;
      end
      cyc = 0; m_busy = 0; m_starve = 0;
    end else begin
      mcur  = cyc;
      melig = bus.cpu_req && !m_busy;
      mw    = model_pick(bus.vid_req, bus.cpu_req, bus.cpu_we, m_busy, m_starve);
      if (ev_ack[mcur & 7]) m_busy = 0;
      case (mw)
        1: begin
          ev_vv[(mcur + 2) & 7] = 1;
          ev_vd[(mcur + 2) & 7] = m_read(int'(bus.vid_addr));
        end
        2: begin
          ev_ack[(mcur + 2) & 7] = 1;
          ev_rd[(mcur + 2) & 7]  = 1;
          ev_rdd[(mcur + 2) & 7] = m_read(int'(bus.cpu_addr));
          m_busy = 1;
        end
        3: begin
          m_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
          ev_ack[(mcur + 1) & 7] = 1;
          m_busy = 1;
        end
        default: ;
      endcase
      if (mw >= 2 || !bus.cpu_req) m_starve = 0;
      else if (melig && m_starve < int'(MAX_WAIT)) m_starve = m_starve + 1;
      ev_vv[mcur & 7] = 0; ev_ack[mcur & 7] = 0; ev_rd[mcur & 7] = 0;
      cyc = mcur + 1;
    end
  end

  task automatic idle(int n);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    @(negedge clk_50mhz);
    outs = {bus.vid_gnt, bus.vid_late, bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
            bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", outs); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      bus.vid_req = 1'b1; bus.vid_addr = ADDR_W'($urandom_range(32, 200));
    end
    #5 rst = 1'b1;
    #1;
    outs = {bus.vid_gnt, bus.vid_late, bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
            bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
    checks++; if (outs !== '0) begin errors++; $display("FAIL midreset_state got %h exp 0", outs); end
    @(negedge clk_50mhz);
    bus.vid_req = 1'b0; rst = 1'b0;
    #1;
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL reset_drop1 got %b exp 0", bus.vid_valid); end
    @(negedge clk_50mhz);
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL reset_drop2 got %b exp 0", bus.vid_valid); end
    bus.vid_req = 1'b1; bus.vid_addr = ADDR_W'(16);
    #1;
    checks++; if (bus.vid_gnt !== 1'b1) begin errors++; $display("FAIL first_gnt got %b exp 1", bus.vid_gnt); end
    @(negedge clk_50mhz);
    bus.vid_req = 1'b0;
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL first_valid_n1 got %b exp 0", bus.vid_valid); end
    @(negedge clk_50mhz);
    checks++; if (bus.vid_valid !== 1'b1) begin errors++; $display("FAIL first_valid_n2 got %b exp 1", bus.vid_valid); end
    checks++; if (bus.vid_data !== init_val(16)) begin errors++; $display("FAIL first_data got %h exp %h", bus.vid_data, init_val(16)); end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk_50mhz);
    bus.vid_req = 1'b0; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = ADDR_W'(16'h0100); bus.cpu_wdata = 8'hA5;
    #1;
    checks++; if (bus.vid_gnt !== 1'b0) begin errors++; $display("FAIL wr_no_vid_gnt got %b exp 0", bus.vid_gnt); end
    @(negedge clk_50mhz);
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b11) begin errors++; $display("FAIL wr_ram_en_we got %b exp 11", {bus.ram_en, bus.ram_we}); end
    checks++; if (bus.ram_addr !== ADDR_W'(16'h0100)) begin errors++; $display("FAIL wr_ram_addr got %h exp 0100", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_ram_wdata got %h exp a5", bus.ram_wdata); end
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    @(negedge clk_50mhz);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
`ifdef VRAM_CPU_READ_EN
    @(negedge clk_50mhz);
    checks++; if ({bus.ram_en, bus.ram_we, bus.cpu_ack} !== 3'b100) begin errors++; $display("FAIL rd_issue got %b exp 100", {bus.ram_en, bus.ram_we, bus.cpu_ack}); end
    @(negedge clk_50mhz);
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %b exp 1", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got %h exp a5", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
`else
    @(negedge clk_50mhz);
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b11) begin errors++; $display("FAIL we_ignored got %b exp 11", {bus.ram_en, bus.ram_we}); end
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL we_ignored_ack got %b exp 1", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rdata_tied got %h exp 00", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    @(negedge clk_50mhz);
    checks++; if ({bus.cpu_ack, bus.cpu_rdata} !== 9'h0) begin errors++; $display("FAIL rdata_tied2 got %h exp 0", {bus.cpu_ack, bus.cpu_rdata}); end
`endif
  endtask

  task automatic test_starvation();
    int denied;
    int lates;
    @(negedge clk_50mhz);
    bus.vid_req = 1'b1; bus.vid_addr = ADDR_W'($urandom);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk_50mhz);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = ADDR_W'($urandom_range(0, 31)); bus.cpu_wdata = 8'($urandom);
      bus.vid_addr = ADDR_W'($urandom);
      denied = 0; lates = 0;
      for (int k = 0; k < 10; k++) begin
        if (k > 0) begin @(negedge clk_50mhz); bus.vid_addr = ADDR_W'($urandom); end
        #1;
        if (bus.vid_late === 1'b1) lates++;
        if (bus.vid_gnt === 1'b1) denied++;
        else break;
      end
      checks++; if (denied != int'(MAX_WAIT)) begin errors++; $display("FAIL starve_denied round %0d got %0d exp %0d", r, denied, MAX_WAIT); end
      checks++; if (lates != 1) begin errors++; $display("FAIL starve_late round %0d got %0d exp 1", r, lates); end
      @(negedge clk_50mhz);
      checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL starve_ack round %0d got %b exp 1", r, bus.cpu_ack); end
      bus.cpu_req = 1'b0;
    end
    @(negedge clk_50mhz);
    bus.vid_req = 1'b0;
  endtask

  task automatic test_alternating();
    int s;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50mhz);
      s = cyc & 7;
      checks++; if (bus.vid_valid !== bit'(i >= 2 && (i % 2) == 0)) begin errors++; $display("FAIL alt_valid cyc %0d got %b exp %b", i, bus.vid_valid, (i >= 2 && (i % 2) == 0)); end
      if (ev_vv[s]) begin
        checks++; if (bus.vid_data !== ev_vd[s]) begin errors++; $display("FAIL alt_data cyc %0d got %h exp %h", i, bus.vid_data, ev_vd[s]); end
      end
      checks++; if (bus.cpu_ack !== ev_ack[s]) begin errors++; $display("FAIL alt_ack cyc %0d got %b exp %b", i, bus.cpu_ack, ev_ack[s]); end
      bus.vid_req = (i % 2) == 0; bus.vid_addr = ADDR_W'($urandom_range(0, 31));
      if (bus.cpu_ack === 1'b1) bus.cpu_req = 1'b0;
      else if (!bus.cpu_req && $urandom_range(0, 1) == 1) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = ADDR_W'($urandom_range(0, 31)); bus.cpu_wdata = 8'($urandom);
      end
      #1;
      checks++; if (bus.vid_gnt !== bus.vid_req) begin errors++; $display("FAIL alt_gnt cyc %0d got %b exp %b", i, bus.vid_gnt, bus.vid_req); end
      checks++; if (bus.vid_late !== 1'b0) begin errors++; $display("FAIL alt_late cyc %0d got %b exp 0", i, bus.vid_late); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_50mhz);
      checks++; if (bus.cpu_ack !== bit'(i % 2)) begin errors++; $display("FAIL b2b_ack cyc %0d got %b exp %b", i, bus.cpu_ack, bit'(i % 2)); end
      checks++; if (bus.ram_en !== bit'(i % 2)) begin errors++; $display("FAIL b2b_ram_en cyc %0d got %b exp %b", i, bus.ram_en, bit'(i % 2)); end
      if (i == 0 || bus.cpu_ack === 1'b1) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = ADDR_W'($urandom_range(0, 31)); bus.cpu_wdata = 8'($urandom);
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_random(int n);
    int  s;
    int  w;
    bit  vg_prev;
    vg_prev = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50mhz);
      s = cyc & 7;
      checks++; if (bus.vid_valid !== ev_vv[s]) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, bus.vid_valid, ev_vv[s]); end
      if (ev_vv[s]) begin
        checks++; if (bus.vid_data !== ev_vd[s]) begin errors++; $display("FAIL rnd_vdata cyc %0d got %h exp %h", i, bus.vid_data, ev_vd[s]); end
      end
      checks++; if (bus.cpu_ack !== ev_ack[s]) begin errors++; $display("FAIL rnd_ack cyc %0d got %b exp %b", i, bus.cpu_ack, ev_ack[s]); end
      if (ev_ack[s]) begin
        checks++; if (bus.cpu_rdata !== (ev_rd[s] ? ev_rdd[s] : 8'h00) && (!READ_EN || ev_rd[s])) begin
          errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", i, bus.cpu_rdata, ev_rdd[s]);
        end
      end
      if (!bus.vid_req || vg_prev) begin
        bus.vid_req = $urandom_range(0, 2) != 0; bus.vid_addr = ADDR_W'($urandom_range(0, 31));
      end
      if (!bus.cpu_req || bus.cpu_ack === 1'b1) begin
        bus.cpu_req = $urandom_range(0, 1) == 1; bus.cpu_we = $urandom_range(0, 1) == 1;
        bus.cpu_addr = ADDR_W'($urandom_range(0, 31)); bus.cpu_wdata = 8'($urandom);
      end
      #1;
      w = model_pick(bus.vid_req, bus.cpu_req, bus.cpu_we, m_busy, m_starve);
      checks++; if (bus.vid_gnt !== bit'(w == 1)) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", i, bus.vid_gnt, (w == 1)); end
      checks++; if (bus.vid_late !== bit'(bus.vid_req && w != 1)) begin errors++; $display("FAIL rnd_late cyc %0d got %b exp %b", i, bus.vid_late, (bus.vid_req && w != 1)); end
      vg_prev = (bus.vid_gnt === 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    test_reset();
    idle(3);
    test_cpu_write_read();
    idle(3);
    test_starvation();
    idle(4);
    test_alternating();
    idle(4);
    test_back_to_back();
    idle(4);
    test_random(400);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM between the VGA scan-out fetcher and the CPU bus port (Memwrite/Addrin/BUS path).
- Video fetch has priority, with a hard per-pixel deadline. CPU accesses are slotted in around it.
- A starvation counter guarantees that the CPU eventually wins.
- Sits between the VGA timing/pixel logic and the VRAM block, in the clk_50mhz domain.

Parameters:
ADDR_W, 13, VRAM address width
DATA_W, 8, VRAM data width (pixel byte)
MAX_WAIT, 4, cycles the CPU may be denied before it is forced to win one slot (1..15)

Ports:
clk_50mhz  in  1  system clock
rst  in  1  asynchronous reset, active-high
vid_req  in  1  video fetch request; level, held until vid_gnt
vid_addr  in  ADDR_W  video fetch address
vid_gnt  out  1  video request accepted this cycle (combinational)
vid_valid  out  1  vid_data valid (1-cycle pulse)
vid_data  out  DATA_W  fetched pixel byte
vid_late  out  1  pulse: vid_req pending but denied this cycle
cpu_req  in  1  CPU request; held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  CPU op complete (1-cycle pulse)
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads
ram_en  out  1  RAM enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, 1 cycle after ram_en

Behaviour:
- Reset (async): ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, vid_valid=0, vid_data=0, cpu_ack=0, cpu_rdata=0, vid_late=0, starve_cnt=0, cpu_busy=0, tag pipeline=NONE.
- Arbitration, cycle N (combinational):
  - cpu_eligible = cpu_req & ~cpu_busy.
  - If cpu_eligible & starve_cnt==MAX_WAIT -> CPU wins.
  - Else if vid_req -> video wins.
  - Else if cpu_eligible -> CPU wins.
  - Else idle.
- Issue: vid_gnt=1 in cycle N when video wins. The ram_* registers load the winner at the end of N. Stage-1 tag is set to VID, CPU_RD or CPU_WR; idle loads ram_en=0 and tag NONE.
- Tag pipeline: stage1 (RAM access cycle N+1) -> stage2 (data cycle N+2).
  - VID at stage2: vid_valid=1, vid_data=ram_rdata (registered at end of N+1, visible N+2). Latency from grant to vid_valid is 2 cycles.
  - CPU_WR at stage1: cpu_ack=1 in N+1.
  - CPU_RD at stage2: cpu_ack=1, cpu_rdata=ram_rdata in N+2.
- cpu_busy: set when the CPU wins; cleared in the cycle cpu_ack is asserted. There is at most one CPU op in flight. cpu_req seen in the ack cycle is not re-arbitrated until the next cycle.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, each cycle cpu_eligible & CPU loses.
  - Clears when the CPU wins or cpu_req=0.
- vid_late = vid_req & ~vid_gnt. It is a diagnostic only; the video request stays pending.
- Back-to-back video grants are allowed every cycle; a 25 MHz pixel stream uses every other slot.
- Simultaneous events:
  - Video and CPU requests in the same cycle: priority rule above.
  - Write followed immediately by a read of the same address, next slot: the read returns the new data (RAM write is complete before the read).
- Reset mid-operation: in-flight tags are discarded; no ack or valid is emitted for them.

Optional Feature:
- Macro: VRAM_CPU_READ_EN.
- Defined: full read/write behaviour as above.
- Undefined:
  - cpu_we is ignored; every CPU request is a write.
  - cpu_rdata is tied to 0.
  - Tag CPU_RD does not exist.

Decomposition:
- vram_pkg: tag enum {TAG_NONE, TAG_VID, TAG_CPU_RD, TAG_CPU_WR}; default ADDR_W/DATA_W localparams.
- One natural combinational sub-module, vram_arb_pick. Inputs: vid_req, cpu_eligible, starve_cnt. Outputs: winner tag. The tag pipeline and counters stay in vram_arbiter.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0 immediately. After release, the first vid_req at 0x0010 gives vid_gnt the same cycle and vid_valid 2 cycles later with the RAM byte.
- CPU write 0xA5 to 0x0100 with video idle -> ram_we=1, ram_addr=0x0100 at N+1; cpu_ack at N+1. A following CPU read of 0x0100 returns cpu_rdata=0xA5 at ack.
- Video continuously requesting with cpu_req held (MAX_WAIT=4) -> CPU is denied exactly 4 cycles, wins on the 5th. vid_late pulses once that cycle. starve_cnt then returns to 0.
- Alternating video requests (25 MHz cadence) plus CPU writes -> CPU is granted in the video-idle slots, vid_late never asserted, every vid_valid exactly 2 cycles after its grant.
- cpu_req held high across cpu_ack -> no duplicate ack; a second op is accepted no earlier than the cycle after ack.
- VRAM_CPU_READ_EN undefined: cpu_we=0 request -> treated as a write (ram_we=1), cpu_ack at N+1, cpu_rdata stays 0.
